// File: rtl/usb_rx_byte_assembler_pkg.sv
// -----------------------------------------------------------------------------
// usb_rx_pkg
//   Shared types and constants for the USB receive byte assembler.
//   - rx_state_t : receiver FSM states (HUNT, RECV, ERR)
//   - rx_err_t   : error codes reported on err_code
//   - USB_SYNC_DEC : decoded SYNC tail (seven 0s then a 1, oldest bit at MSB)
//   - sync_shift : helper that appends the newest bit to the SYNC window
// -----------------------------------------------------------------------------
package usb_rx_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'b00,
    RECV = 2'b01,
    ERR  = 2'b10
  } rx_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_STUFF   = 2'b01,
    ERR_PARTIAL = 2'b10,
    ERR_OVF     = 2'b11
  } rx_err_t;

  localparam logic [7:0] USB_SYNC_DEC = 8'h01;

  // Oldest bit sits at the MSB so the window reads like the wire in time order.
  function automatic logic [7:0] sync_shift(input logic [7:0] sr, input logic b);
    return {sr[6:0], b};
  endfunction

endpackage

// File: rtl/usb_rx_byte_assembler_shift8.sv
// -----------------------------------------------------------------------------
// usb_rx_shift8
//   8-bit LSB-first shift register with a 3-bit bit counter.
//   Ports:
//     clk, rst_n  : clock, async active-low reset
//     shift_en    : shift in_bit this cycle
//     clr         : clear register and counter (wins over shift_en)
//     in_bit      : serial data bit
//     out_byte    : byte as it will look once in_bit is shifted in
//     byte_done   : this shift completes the 8th bit of a byte
//     bit_cnt     : number of bits already held for the current byte
// -----------------------------------------------------------------------------
module usb_rx_shift8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift_en,
  input  logic       clr,
  input  logic       in_bit,
  output logic [7:0] out_byte,
  output logic       byte_done,
  output logic [2:0] bit_cnt
);

  logic [7:0] sr;

  // Shift register and bit counter; the counter wraps to 0 after the 8th bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= 8'h00;
      bit_cnt <= 3'd0;
    end else if (clr) begin
      sr      <= 8'h00;
      bit_cnt <= 3'd0;
    end else if (shift_en) begin
      sr      <= {in_bit, sr[7:1]};
      bit_cnt <= bit_cnt + 3'd1;
    end else begin
      sr      <= sr;
      bit_cnt <= bit_cnt;
    end
  end

  // Look-ahead view so the consumer can capture the full byte on the 8th edge.
  assign out_byte  = {in_bit, sr[7:1]};
  assign byte_done = shift_en && (bit_cnt == 3'd7);

endmodule

// File: rtl/usb_rx_byte_assembler.sv
// -----------------------------------------------------------------------------
// usb_rx_byte_assembler
//   Sits behind the bit destuffer. Hunts for the SYNC tail, then assembles
//   destuffed bits LSB-first into bytes, reports stuff / partial-byte /
//   overflow errors and frames the packet on EOP.
//   Ports:
//     clk, rst_n     : clock, async active-low reset
//     bit_tick       : one pulse per received bit time (stuffed bits included)
//     bit_in         : decoded bit, valid with bit_tick
//     bit_strobe     : 1 = data bit, 0 with bit_tick = stuffed bit
//     eop            : end-of-packet pulse
//     rx_data        : assembled byte (first received bit at LSB)
//     rx_data_valid  : one-cycle pulse, rx_data valid
//     rx_active      : high from SYNC match until EOP
//     rx_error       : one-cycle error pulse
//     err_code       : last error code, held until the next error
//     byte_count     : bytes delivered in the current/last packet
// -----------------------------------------------------------------------------
module usb_rx_byte_assembler
  import usb_rx_pkg::*;
#(
  parameter logic [7:0]  SYNC_PATTERN = USB_SYNC_DEC,
  parameter int unsigned MAX_BYTES    = 1027,
  parameter int unsigned CNT_W        = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_tick,
  input  logic             bit_in,
  input  logic             bit_strobe,
  input  logic             eop,
  output logic [7:0]       rx_data,
  output logic             rx_data_valid,
  output logic             rx_active,
  output logic             rx_error,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] byte_count
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  rx_state_t  state;
  rx_err_t    err_q;
  logic [7:0] sync_sr;
  logic [7:0] sync_next;
  logic       shift_en;
  logic       shift_clr;
  logic [7:0] asm_byte;
  logic       byte_done;
  logic [2:0] bit_cnt;

  assign sync_next = sync_shift(sync_sr, bit_in);
  // eop has priority over a coincident bit, so the bit never reaches the shifter.
  assign shift_en  = (state == RECV) && bit_tick && bit_strobe && !eop;
  // Outside RECV the shifter is held empty, so every packet starts at bit 0.
  assign shift_clr = (state != RECV);
  assign err_code  = err_q;

  usb_rx_shift8 u_shift8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (shift_en),
    .clr       (shift_clr),
    .in_bit    (bit_in),
    .out_byte  (asm_byte),
    .byte_done (byte_done),
    .bit_cnt   (bit_cnt)
  );

  // Receiver FSM with registered outputs, byte counter and error reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HUNT;
      err_q         <= ERR_NONE;
      sync_sr       <= 8'h00;
      rx_data       <= 8'h00;
      rx_data_valid <= 1'b0;
      rx_active     <= 1'b0;
      rx_error      <= 1'b0;
      byte_count    <= {CNT_W{1'b0}};
    end else begin
      rx_data_valid <= 1'b0;
      rx_error      <= 1'b0;
      case (state)
        HUNT: begin
          if (bit_tick) begin
            sync_sr <= sync_next;
            if (sync_next == SYNC_PATTERN) begin
              state      <= RECV;
              rx_active  <= 1'b1;
              byte_count <= {CNT_W{1'b0}};
            end
          end
        end
        RECV: begin
          if (eop) begin
            state     <= HUNT;
            rx_active <= 1'b0;
            sync_sr   <= 8'h00;
            // Leftover bits mean the packet ended mid-byte; they are dropped.
            if (bit_cnt != 3'd0) begin
              rx_error <= 1'b1;
              err_q    <= ERR_PARTIAL;
            end
          end else if (bit_tick) begin
            if (bit_strobe) begin
              if (byte_done) begin
                if (byte_count == MAX_CNT) begin
                  rx_error <= 1'b1;
                  err_q    <= ERR_OVF;
                  state    <= ERR;
                end else begin
                  rx_data       <= asm_byte;
                  rx_data_valid <= 1'b1;
                  byte_count    <= byte_count + CNT_ONE;
                end
              end
            end else if (bit_in) begin
              // A stuffed bit must always be 0.
              rx_error <= 1'b1;
              err_q    <= ERR_STUFF;
              state    <= ERR;
            end
          end
        end
        ERR: begin
          if (eop) begin
            state     <= HUNT;
            rx_active <= 1'b0;
            sync_sr   <= 8'h00;
          end
        end
        default: begin
          state     <= HUNT;
          rx_active <= 1'b0;
          sync_sr   <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_byte_assembler.sv
// -----------------------------------------------------------------------------
// tb_usb_rx_byte_assembler
//   Self-checking bench. Stimulus is driven bit by bit; a packet-level model
//   (bit lists grouped into bytes) predicts delivered bytes, error codes,
//   byte_count and rx_active. MAX_BYTES is 4 so overflow is reachable.
// -----------------------------------------------------------------------------
module tb_usb_rx_byte_assembler;

  localparam int MAXB = 4;
  localparam int CW   = 11;

  logic          clk;
  logic          rst_n;
  logic          bit_tick;
  logic          bit_in;
  logic          bit_strobe;
  logic          eop;
  logic [7:0]    rx_data;
  logic          rx_data_valid;
  logic          rx_active;
  logic          rx_error;
  logic [1:0]    err_code;
  logic [CW-1:0] byte_count;

  int tests_run = 0;
  int fails     = 0;

  // observed and expected streams
  logic [7:0] got_bytes[$];
  logic [7:0] got_errs[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] exp_errs[$];

  // packet-level model state
  int         m_mode;      // 0 hunting, 1 receiving, 2 waiting for eop after error
  logic [7:0] m_win;       // last eight bits seen while hunting
  int         m_bits[$];   // data bits of the byte in progress
  int         m_nbytes;
  logic       m_active;
  logic [1:0] m_err;
  int         ones_run;

  usb_rx_byte_assembler #(
    .SYNC_PATTERN (8'h01),
    .MAX_BYTES    (MAXB),
    .CNT_W        (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bit_tick      (bit_tick),
    .bit_in        (bit_in),
    .bit_strobe    (bit_strobe),
    .eop           (eop),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_active     (rx_active),
    .rx_error      (rx_error),
    .err_code      (err_code),
    .byte_count    (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // collect DUT output events
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_data_valid) got_bytes.push_back(rx_data);
      if (rx_error)      got_errs.push_back({6'd0, err_code});
    end
  end

  function automatic logic [71:0] sig8(input logic [7:0] q[$]);
    logic [63:0] d;
    d = 64'd0;
    for (int i = 0; i < q.size() && i < 8; i++) d = {d[55:0], q[i]};
    return {8'(q.size()), d};
  endfunction

  task automatic model_reset();
    m_mode   = 0;
    m_win    = 8'h00;
    m_bits.delete();
    m_nbytes = 0;
    m_active = 1'b0;
    m_err    = 2'b00;
  endtask

  task automatic clear_obs();
    got_bytes.delete();
    got_errs.delete();
    exp_bytes.delete();
    exp_errs.delete();
  endtask

  // Packet rules: SYNC opens, 8 data bits make a byte, eop closes.
  task automatic model_step(input logic tk, input logic b, input logic st, input logic e);
    int v;
    if (m_mode == 0) begin
      if (tk) begin
        m_win = {m_win[6:0], b};
        if (m_win == 8'h01) begin
          m_mode = 1; m_active = 1'b1; m_nbytes = 0; m_bits.delete();
        end
      end
    end else if (m_mode == 1) begin
      if (e) begin
        if (m_bits.size() != 0) begin exp_errs.push_back(8'd2); m_err = 2'b10; end
        m_mode = 0; m_active = 1'b0; m_win = 8'h00; m_bits.delete();
      end else if (tk && st) begin
        m_bits.push_back(int'(b));
        if (m_bits.size() == 8) begin
          v = 0;
          for (int i = 0; i < 8; i++) v = v + (m_bits[i] << i);
          m_bits.delete();
          if (m_nbytes == MAXB) begin
            exp_errs.push_back(8'd3); m_err = 2'b11; m_mode = 2;
          end else begin
            exp_bytes.push_back(8'(v)); m_nbytes = m_nbytes + 1;
          end
        end
      end else if (tk && b) begin
        exp_errs.push_back(8'd1); m_err = 2'b01; m_mode = 2; m_bits.delete();
      end
    end else begin
      if (e) begin m_mode = 0; m_active = 1'b0; m_win = 8'h00; end
    end
  endtask

  task automatic step(input logic tk, input logic b, input logic st, input logic e);
    @(negedge clk);
    bit_tick = tk; bit_in = b; bit_strobe = st; eop = e;
    @(negedge clk);
    bit_tick = 1'b0; eop = 1'b0;
    bit_in = 1'($urandom); bit_strobe = 1'($urandom);
    model_step(tk, b, st, e);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_sync();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    ones_run = 0;
  endtask

  // data byte, LSB first, with a stuffed 0 after six consecutive 1s
  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, v[i], 1'b1, 1'b0);
      ones_run = v[i] ? ones_run + 1 : 0;
      if (ones_run == 6) begin
        step(1'b1, 1'b0, 1'b0, 1'b0);
        ones_run = 0;
      end
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bit_tick = 1'b0; bit_in = 1'b0; bit_strobe = 1'b0; eop = 1'b0;
    model_reset(); clear_obs();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({rx_data, rx_data_valid, rx_active, rx_error, err_code, byte_count} !== {8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 11'd0}) begin
      fails++; $display("FAIL reset_outputs: got %h required 0", {rx_data, rx_data_valid, rx_active, rx_error, err_code, byte_count});
    end
    rst_n = 1'b1;
    // partial packet then reset mid-RECV
    send_sync();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    tests_run++;
    if (rx_active !== 1'b1) begin fails++; $display("FAIL reset_pre_active: got %b required 1", rx_active); end
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({rx_data, rx_data_valid, rx_active, rx_error, err_code, byte_count} !== {8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 11'd0}) begin
      fails++; $display("FAIL reset_mid_packet: got %h required 0", {rx_data, rx_data_valid, rx_active, rx_error, err_code, byte_count});
    end
    rst_n = 1'b1;
    model_reset(); clear_obs();
    send_sync(); send_byte(8'h5A); step(1'b0, 1'b0, 1'b0, 1'b1); settle();
    tests_run++;
    if (sig8(got_bytes) !== sig8(exp_bytes) || got_bytes.size() != 1 || got_errs.size() != 0) begin
      fails++; $display("FAIL reset_after_packet: got %h required %h", sig8(got_bytes), sig8(exp_bytes));
    end
  endtask

  task automatic test_basic_byte();
    clear_obs();
    send_sync(); send_byte(8'hA5);
    tests_run++;
    if (rx_active !== 1'b1) begin fails++; $display("FAIL basic_active: got %b required 1", rx_active); end
    step(1'b0, 1'b0, 1'b0, 1'b1); settle();
    tests_run++;
    if (sig8(got_bytes) !== {8'd1, 56'd0, 8'hA5}) begin
      fails++; $display("FAIL basic_byte: got %h required %h", sig8(got_bytes), {8'd1, 56'd0, 8'hA5});
    end
    tests_run++;
    if ({rx_active, byte_count, 8'(got_errs.size())} !== {1'b0, 11'd1, 8'd0}) begin
      fails++; $display("FAIL basic_end: active %b count %0d errs %0d required 0 1 0", rx_active, byte_count, got_errs.size());
    end
  endtask

  task automatic test_stuffing();
    clear_obs();
    send_sync(); send_byte(8'hFF); step(1'b0, 1'b0, 1'b0, 1'b1); settle();
    tests_run++;
    if (sig8(got_bytes) !== {8'd1, 56'd0, 8'hFF} || got_errs.size() != 0) begin
      fails++; $display("FAIL stuff_ok: got %h errs %0d required %h", sig8(got_bytes), got_errs.size(), {8'd1, 56'd0, 8'hFF});
    end
    clear_obs();
    send_sync();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    tests_run++;
    if ({rx_active, err_code, 8'(got_bytes.size())} !== {1'b1, 2'b01, 8'd0} || sig8(got_errs) !== sig8(exp_errs)) begin
      fails++; $display("FAIL stuff_err: active %b code %b bytes %0d errs %h required 1 01 0 %h", rx_active, err_code, got_bytes.size(), sig8(got_errs), sig8(exp_errs));
    end
    step(1'b0, 1'b0, 1'b0, 1'b1); settle();
    tests_run++;
    if (rx_active !== 1'b0) begin fails++; $display("FAIL stuff_err_eop: active %b required 0", rx_active); end
  endtask

  task automatic test_partial();
    clear_obs();
    send_sync(); send_byte(8'h3C);
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1); settle();
    tests_run++;
    if (sig8(got_bytes) !== {8'd1, 56'd0, 8'h3C} || sig8(got_errs) !== {8'd1, 56'd0, 8'h02} || err_code !== 2'b10) begin
      fails++; $display("FAIL partial: bytes %h errs %h code %b required 3C one err 10", sig8(got_bytes), sig8(got_errs), err_code);
    end
  endtask

  task automatic test_overflow();
    clear_obs();
    send_sync();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h11 * (i + 1)));
    settle();
    tests_run++;
    if (sig8(got_bytes) !== {8'd4, 32'd0, 8'h11, 8'h22, 8'h33, 8'h44} || err_code !== 2'b11 || byte_count !== 11'd4) begin
      fails++; $display("FAIL overflow: bytes %h code %b count %0d required 11223344 11 4", sig8(got_bytes), err_code, byte_count);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_sync(); settle();
    tests_run++;
    if ({byte_count, rx_active} !== {11'd0, 1'b1}) begin
      fails++; $display("FAIL overflow_resync: count %0d active %b required 0 1", byte_count, rx_active);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1); settle();
  endtask

  task automatic test_eop_collision();
    clear_obs();
    send_sync();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1); settle();
    tests_run++;
    if (got_bytes.size() != 0 || sig8(got_errs) !== {8'd1, 56'd0, 8'h02} || rx_active !== 1'b0) begin
      fails++; $display("FAIL eop_collision: bytes %0d errs %h active %b required 0 one 10 0", got_bytes.size(), sig8(got_errs), rx_active);
    end
    clear_obs();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'($urandom), 1'b0);
    settle();
    tests_run++;
    if (rx_active !== 1'b0 || got_bytes.size() != 0) begin
      fails++; $display("FAIL hunt_zeros: active %b bytes %0d required 0 0", rx_active, got_bytes.size());
    end
  endtask

  task automatic test_random_packets();
    int nb;
    for (int p = 0; p < 12; p++) begin
      clear_obs();
      for (int j = 0; j < int'($urandom_range(0, 5)); j++) step(1'b1, 1'($urandom), 1'b1, 1'b0);
      send_sync();
      nb = int'($urandom_range(0, 5));
      for (int j = 0; j < nb; j++) send_byte(8'($urandom));
      if ($urandom_range(0, 3) == 0)
        for (int j = 0; j < int'($urandom_range(1, 7)); j++) step(1'b1, 1'($urandom), 1'b1, 1'b0);
      if ($urandom_range(0, 5) == 0) step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1); settle();
      tests_run++;
      if (sig8(got_bytes) !== sig8(exp_bytes) || sig8(got_errs) !== sig8(exp_errs)) begin
        fails++; $display("FAIL random_%0d_stream: bytes %h errs %h required %h %h", p, sig8(got_bytes), sig8(got_errs), sig8(exp_bytes), sig8(exp_errs));
      end
      tests_run++;
      if ({byte_count, rx_active, err_code} !== {11'(m_nbytes), m_active, m_err}) begin
        fails++; $display("FAIL random_%0d_status: count %0d active %b code %b required %0d %b %b", p, byte_count, rx_active, err_code, m_nbytes, m_active, m_err);
      end
    end
  endtask

  initial begin
    ones_run = 0;
    test_reset();
    test_basic_byte();
    test_stuffing();
    test_partial();
    test_overflow();
    test_eop_collision();
    test_random_packets();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
